// File: rtl/eprisc_intc_pkg.sv
// Shared types and constants for the epRISC interrupt controller.
// The optional input synchronizer is enabled with EPRISC_INTC_SYNC_EN.
package eprisc_intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } intcState_t;

    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_CLAIM   = 2'd2;
    localparam logic [1:0] ADDR_MODE    = 2'd3;

    localparam int          CLAIM_VALID_BIT = 15;
    localparam logic [15:0] NO_CLAIM        = 16'h0000;

    function automatic logic [15:0] claimWord(input logic [3:0] index);
        logic [15:0] word;
        word = {12'd0, index};
        word[CLAIM_VALID_BIT] = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/eprisc_intc_source.sv
// One interrupt source: optional two-flop synchronizer (EPRISC_INTC_SYNC_EN),
// rising-edge detector and the pending bit for level or edge mode.
module eprisc_intc_source
    import eprisc_intc_pkg::*;
(
    input  logic iClock,
    input  logic iReset,
    input  logic iSource,
    input  logic iMode,
    input  logic iClear,
    input  logic iClaimClear,
    output logic oPending,
    output logic oPendingNext
);

    logic sampled;
    logic previous;

`ifdef EPRISC_INTC_SYNC_EN
    logic [1:0] syncStage;

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            syncStage <= '0;
        end else begin
            syncStage <= {syncStage[0], iSource};
        end
    end

    assign sampled = syncStage[1];
`else
    assign sampled = iSource;
`endif

    // A fresh edge beats a same-cycle W1C or claim clear.
    always_comb begin
        oPendingNext = oPending;
        if (iMode) begin
            if (sampled && !previous) begin
                oPendingNext = 1'b1;
            end else if (iClear || iClaimClear) begin
                oPendingNext = 1'b0;
            end
        end else begin
            oPendingNext = sampled;
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            previous <= 1'b0;
            oPending <= 1'b0;
        end else begin
            previous <= sampled;
            oPending <= oPendingNext;
        end
    end

endmodule

// File: rtl/eprisc_interrupt_controller.sv
// Prioritized interrupt controller with MASK/PENDING/CLAIM/MODE bus registers.
// Define EPRISC_INTC_SYNC_EN to synchronize asynchronous sources.
module eprisc_interrupt_controller
    import eprisc_intc_pkg::*;
#(
    parameter int SOURCES = 8
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic [SOURCES-1:0] iSource,
    input  logic [1:0]         iAddress,
    input  logic [15:0]        iData,
    output logic [15:0]        oData,
    input  logic               iWrite,
    input  logic               iEnable,
    output logic               oInterrupt,
    output logic [1:0]         oState
);

    intcState_t         state;
    logic [3:0]         activeIndex;
    logic [3:0]         winner;
    logic [SOURCES-1:0] mask, mode, maskNext, modeNext;
    logic [SOURCES-1:0] pending, pendingNext, w1c, claimClear;
    logic [SOURCES-1:0] eligible, eligibleNext;
    logic [15:0]        readData;
    logic               busRead, busWrite, claimRead, claimTake, eoiWrite;
    logic               unusedBits;

    assign busRead   = iEnable && !iWrite;
    assign busWrite  = iEnable && iWrite;
    assign claimRead = busRead && (iAddress == ADDR_CLAIM);
    assign claimTake = claimRead && (state == ASSERT);
    assign eoiWrite  = busWrite && (iAddress == ADDR_CLAIM);

    assign maskNext = (busWrite && iAddress == ADDR_MASK) ? iData[SOURCES-1:0] : mask;
    assign modeNext = (busWrite && iAddress == ADDR_MODE) ? iData[SOURCES-1:0] : mode;
    assign w1c      = (busWrite && iAddress == ADDR_PENDING) ? iData[SOURCES-1:0] : '0;
    assign unusedBits = ^iData[15:SOURCES];

    assign eligible     = pending & mask;
    assign eligibleNext = pendingNext & maskNext;
    assign oState       = state;

    always_comb begin
        winner = '0;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 4'(i);
            end
        end
    end

    always_comb begin
        claimClear = '0;
        for (int i = 0; i < SOURCES; i++) begin
            claimClear[i] = claimTake && (winner == 4'(i));
        end
    end

    for (genvar i = 0; i < SOURCES; i++) begin : gSource
        eprisc_intc_source uSource (
            .iClock      (iClock),
            .iReset      (iReset),
            .iSource     (iSource[i]),
            .iMode       (mode[i]),
            .iClear      (w1c[i]),
            .iClaimClear (claimClear[i]),
            .oPending    (pending[i]),
            .oPendingNext(pendingNext[i])
        );
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            mask <= '0;
            mode <= '0;
        end else begin
            mask <= maskNext;
            mode <= modeNext;
        end
    end

    // Transitions look at next-cycle eligibility so ASSERT always has a winner.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state       <= IDLE;
            activeIndex <= '0;
            oInterrupt  <= 1'b0;
        end else begin
            oInterrupt <= (state == ASSERT);
            case (state)
                IDLE: begin
                    if (|eligibleNext) state <= ASSERT;
                end
                ASSERT: begin
                    if (claimRead) begin
                        state       <= SERVICE;
                        activeIndex <= winner;
                    end else if (!(|eligibleNext)) begin
                        state <= IDLE;
                    end
                end
                SERVICE: begin
                    if (eoiWrite) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        readData = NO_CLAIM;
        case (iAddress)
            ADDR_MASK:    readData = 16'(mask);
            ADDR_PENDING: readData = 16'(pending);
            ADDR_CLAIM: begin
                if (state == ASSERT)       readData = claimWord(winner);
                else if (state == SERVICE) readData = claimWord(activeIndex);
            end
            default:      readData = 16'(mode);
        endcase
    end

    assign oData = busRead ? readData : 16'hzzzz;

endmodule
